// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler: regenerates the LFSR keystream, recovers payload words
// and checks the trailing XOR checksum word of each frame.
module xor_stream_descrambler #(
    parameter logic [31:0] POLY = 32'h04C11DB7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_seed_load,
    input  logic [31:0] i_seed,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_data,
    input  logic        i_in_last,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_chk_done,
    output logic        o_chk_ok,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, READY, FRAME} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_lfsr, r_acc, r_out_data;
    logic        r_out_valid, r_chk_done, r_chk_ok;
    logic        w_accept;
    logic [31:0] w_plain, w_lfsr_step;

    // Seed load owns the cycle; a held output word blocks input until drained.
    assign o_in_ready  = (r_state != IDLE) && !i_seed_load && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_plain     = i_in_data ^ r_lfsr;
    assign w_lfsr_step = {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? POLY : 32'h0);

    always_comb begin
        w_state_next = r_state;
        if (i_seed_load)
            w_state_next = READY;
        else if (w_accept)
            w_state_next = i_in_last ? READY : FRAME;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_lfsr     <= 32'h1;
            r_acc      <= 32'h0;
            r_chk_done <= 1'b0;
            r_chk_ok   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_chk_done <= 1'b0;
            if (i_seed_load) begin
                r_lfsr <= (i_seed == 32'h0) ? 32'h1 : i_seed;
                r_acc  <= 32'h0;
                if (r_state == FRAME) begin
                    r_chk_done <= 1'b1;
                    r_chk_ok   <= 1'b0;
                end
            end else if (w_accept) begin
                r_lfsr <= w_lfsr_step;
                if (i_in_last) begin
                    r_chk_done <= 1'b1;
                    r_chk_ok   <= (w_plain == r_acc);
                    r_acc      <= 32'h0;
                end else begin
                    r_acc <= r_acc ^ w_plain;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
        end else if (w_accept && !i_in_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_plain;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_chk_done  = r_chk_done;
    assign o_chk_ok    = r_chk_ok;
    assign o_busy      = (r_state == FRAME);
endmodule

// File: tb/tb_xor_stream_descrambler.sv
// tb_xor_stream_descrambler: randomized scoreboard bench with a keystream model
// based on multiplication by x modulo the feedback polynomial.
module tb_xor_stream_descrambler;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        seed_load = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] seed = 32'h0, in_data = 32'h0;
    logic        in_ready, out_valid, chk_done, chk_ok, busy;
    logic [31:0] out_data;

    xor_stream_descrambler #(.POLY(POLY)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed(seed),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_last(in_last),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_chk_done(chk_done), .o_chk_ok(chk_ok), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0, pct = 100;
    logic [31:0] exp_q[$];
    logic        chk_q[$];
    logic [31:0] m_ks = 32'h1, m_acc = 32'h0;
    bit          m_frame = 0, m_seeded = 0, mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Keystream step: multiply by x in GF(2)[x] and reduce modulo x^32 + POLY.
    function automatic logic [31:0] ks_next(input logic [31:0] k);
        logic [32:0] w;
        w = 33'(k) * 33'd2;
        if (w >= 33'h1_0000_0000) w = w ^ {1'b1, POLY};
        return w[31:0];
    endfunction

    function automatic logic rnd();
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic model_accept(input logic [31:0] d, input logic last);
        logic [31:0] plain;
        plain = d ^ m_ks;
        m_ks = ks_next(m_ks);
        if (!last) begin
            exp_q.push_back(plain);
            m_acc ^= plain;
            m_frame = 1;
        end else begin
            chk_q.push_back(plain == m_acc);
            m_acc = 0;
            m_frame = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1; in_data = d; in_last = last; out_ready = rnd();
        #1;
        while (!in_ready && t < 60) begin
            t++;
            @(negedge clk);
            out_ready = rnd();
            #1;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 0;
            return;
        end
        @(posedge clk);
        model_accept(d, last);
        #1 in_valid = 0;
    endtask

    task automatic send_good_last();
        send(m_acc ^ m_ks, 1'b1);
    endtask

    task automatic do_seed(input logic [31:0] s);
        @(negedge clk);
        seed_load = 1; seed = s; in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; in_last = 0;
        out_ready = rnd();
        #1 check("in_ready_during_seed", {31'b0, in_ready}, 32'h0);
        @(posedge clk);
        m_ks = (s == 32'h0) ? 32'h1 : s;
        m_acc = 0;
        if (m_frame) chk_q.push_back(1'b0);
        m_frame = 0;
        m_seeded = 1;
        #1 seed_load = 0; in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        pct = 100;
        @(negedge clk);
        out_ready = 1;
        while ((exp_q.size() != 0 || chk_q.size() != 0 || out_valid) && t < 30) begin
            t++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: sample after the driver has settled inputs for the cycle.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("unexpected_output");
                else check("out_data", out_data, exp_q.pop_front());
            end
            if (chk_done) begin
                if (chk_q.size() == 0) fail("unexpected_chk_done");
                else check("chk_ok", {31'b0, chk_ok}, {31'b0, chk_q.pop_front()});
            end
            check("busy", {31'b0, busy}, {31'b0, m_frame});
            if (!m_seeded) check("in_ready_unseeded", {31'b0, in_ready}, 32'h0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_chk_done", {31'b0, chk_done}, 32'h0);
        check("rst_chk_ok", {31'b0, chk_ok}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1;
        mon_en = 1;

        // Unseeded: nothing may be accepted
        in_valid = 1; in_data = 32'h1234_5678; out_ready = 1;
        repeat (5) @(negedge clk);
        in_valid = 0;

        // Good frame, back-to-back, with exact chk_done timing
        do_seed(32'h1);
        send(32'hA5A5A5A4, 0);
        send(32'h0F0F0F0D, 0);
        send(32'hAAAAAAAE, 1);
        @(negedge clk);
        #2 check("chk_done_next_cycle", {31'b0, chk_done}, 32'h1);
        @(negedge clk);
        #2 check("chk_done_one_cycle", {31'b0, chk_done}, 32'h0);

        // Bad checksum
        do_seed(32'h1);
        send(32'hA5A5A5A4, 0);
        send(32'h0F0F0F0D, 0);
        send(32'hAAAAAAAF, 1);
        drain();

        // Backpressure for 3 cycles after the first output
        do_seed(32'h1);
        send(32'hA5A5A5A4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 0; in_valid = 1; in_data = 32'h0F0F0F0D; in_last = 0;
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'h0);
            check("bp_out_valid", {31'b0, out_valid}, 32'h1);
            check("bp_out_data_held", out_data, 32'hA5A5A5A5);
        end
        in_valid = 0;
        send(32'h0F0F0F0D, 0);
        send(32'hAAAAAAAE, 1);
        drain();

        // Abort with seed 0x80000000 after one payload word
        do_seed(32'h1);
        send(32'hA5A5A5A4, 0);
        do_seed(32'h8000_0000);
        send(32'h84C11DB7, 0);
        send(32'h04C11DB7 ^ 32'hDEAD_BEEF, 0);
        send_good_last();
        drain();

        // Zero seed behaves as seed 1
        do_seed(32'h0);
        send(32'h1, 0);
        send_good_last();
        send(32'h0, 1);
        drain();

        // Asynchronous reset while an output word is held
        do_seed(32'h5555_0001);
        pct = 0;
        send($urandom, 0);
        @(negedge clk);
        #3;
        mon_en = 0;
        rst_n = 0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_out_data", out_data, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_in_ready", {31'b0, in_ready}, 32'h0);
        exp_q.delete(); chk_q.delete();
        m_ks = 32'h1; m_acc = 0; m_frame = 0; m_seeded = 0;
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        pct = 100;
        in_valid = 1; in_data = 32'hFFFF_FFFF; out_ready = 1;
        repeat (3) @(negedge clk);
        in_valid = 0;

        // Randomized frames, backpressure, aborts and reseeds
        do_seed($urandom);
        for (int f = 0; f < 40; f++) begin
            pct = $urandom_range(30, 100);
            if ($urandom_range(0, 4) == 0) do_seed($urandom_range(0, 3) == 0 ? 32'h0 : $urandom);
            for (int w = $urandom_range(0, 6); w > 0; w--) send($urandom, 0);
            if ($urandom_range(0, 5) == 0) do_seed($urandom);
            else if ($urandom_range(0, 2) == 0) send($urandom, 1);
            else send_good_last();
        end
        drain();
        check("exp_q_empty", exp_q.size(), 32'h0);
        check("chk_q_empty", chk_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
